// File: rtl/nf10_ipif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nf10_ipif_pkg
// Description : Shared helpers for the NetFPGA-10G IPIF register files.
//               Provides address-map derivation (region bases, word index
//               position/width) and port-width helpers for empty regions.
// Revision    : 1.0 - initial release
// ============================================================================
package nf10_ipif_pkg;

    // Word index of the first WO register; every other base is derived from
    // the region sizes of the instantiating module.
    localparam int WO_BASE = 0;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int rw_base(input int n_wo);
        return WO_BASE + n_wo;
    endfunction

    function automatic int w1c_base(input int n_wo, input int n_rw);
        return rw_base(n_wo) + n_rw;
    endfunction

    function automatic int ro_base(input int n_wo, input int n_rw, input int n_w1c);
        return w1c_base(n_wo, n_rw) + n_w1c;
    endfunction

    // Byte-offset bits below the word index.
    function automatic int calc_addr_lsb(input int data_width);
        return clog2(data_width / 8);
    endfunction

    // Word index width; never narrower than one bit.
    function automatic int calc_idx_w(input int total_regs);
        return (clog2(total_regs) < 1) ? 1 : clog2(total_regs);
    endfunction

    // Width of a per-region port: an empty region keeps a 1-bit tie-off.
    function automatic int port_w(input int n_regs, input int bits_per_reg);
        return (n_regs == 0) ? 1 : n_regs * bits_per_reg;
    endfunction

endpackage : nf10_ipif_pkg
`default_nettype wire

// File: rtl/ipif_w1c_reg.sv
`default_nettype none
// ============================================================================
// Module      : ipif_w1c_reg
// Description : One sticky status register. Hardware sets bits, software
//               clears them by writing 1 on enabled byte lanes. A set and a
//               clear on the same bit in the same cycle leaves the bit set.
// Revision    : 1.0 - initial release
// ============================================================================
module ipif_w1c_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH-1:0]   i_set,
    output logic [DATA_WIDTH-1:0]   o_q
);

    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] w_clr;

    // Clear mask: write data gated by the enabled byte lanes.
    always_comb begin
        w_clr = '0;
        if (i_wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                w_clr[b*8 +: 8] = i_wdata[b*8 +: 8] & {8{i_be[b]}};
            end
        end
    end

    // Sticky update; OR-ing the set term last lets set win over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= (r_q & ~w_clr) | i_set;
        end
    end

    assign o_q = r_q;

endmodule : ipif_w1c_reg
`default_nettype wire

// File: rtl/ipif_regs_ext.sv
`default_nettype none
// ============================================================================
// Module      : ipif_regs_ext
// Description : IPIF register file with WO, RW, W1C and RO regions, byte
//               enables, write/read strobes, out-of-range error response,
//               one ack per access and a level interrupt from W1C bits.
// Revision    : 1.0 - initial release
// ============================================================================
module ipif_regs_ext
    import nf10_ipif_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_WO_REGS        = 0,
    parameter int NUM_RW_REGS        = 0,
    parameter int NUM_W1C_REGS       = 0,
    parameter int NUM_RO_REGS        = 0,
    parameter logic [port_w(NUM_WO_REGS+NUM_RW_REGS, C_S_AXI_DATA_WIDTH)-1:0] RESET_VALUES = '0
) (
    input  logic                                                 Bus2IP_Clk,
    input  logic                                                 Bus2IP_Reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                        Bus2IP_Addr,
    input  logic                                                 Bus2IP_CS,
    input  logic                                                 Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                        Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                      Bus2IP_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                        IP2Bus_Data,
    output logic                                                 IP2Bus_RdAck,
    output logic                                                 IP2Bus_WrAck,
    output logic                                                 IP2Bus_Error,
    output logic [port_w(NUM_WO_REGS, C_S_AXI_DATA_WIDTH)-1:0]   wo_regs,
    output logic [port_w(NUM_RW_REGS, C_S_AXI_DATA_WIDTH)-1:0]   rw_regs,
    output logic [port_w(NUM_WO_REGS+NUM_RW_REGS, 1)-1:0]        wr_strobe,
    input  logic [port_w(NUM_W1C_REGS, C_S_AXI_DATA_WIDTH)-1:0]  w1c_set,
    output logic [port_w(NUM_W1C_REGS, C_S_AXI_DATA_WIDTH)-1:0]  w1c_regs,
    input  logic [port_w(NUM_RO_REGS, C_S_AXI_DATA_WIDTH)-1:0]   ro_regs,
    output logic [port_w(NUM_RO_REGS, 1)-1:0]                    ro_rd_strobe,
    output logic                                                 irq
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int BE_W      = DW / 8;
    localparam int NUM_CTL   = NUM_WO_REGS + NUM_RW_REGS;
    localparam int TOTAL     = NUM_CTL + NUM_W1C_REGS + NUM_RO_REGS;
    localparam int RW_BASE   = rw_base(NUM_WO_REGS);
    localparam int W1C_BASE  = w1c_base(NUM_WO_REGS, NUM_RW_REGS);
    localparam int RO_BASE   = ro_base(NUM_WO_REGS, NUM_RW_REGS, NUM_W1C_REGS);
    localparam int ADDR_LSB  = calc_addr_lsb(DW);
    localparam int IDX_W     = calc_idx_w(TOTAL);
    localparam int CTL_W     = port_w(NUM_CTL, DW);
    localparam int W1C_W     = port_w(NUM_W1C_REGS, DW);

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_idx_u;
    logic             w_busy;
    logic             w_accept;
    logic             w_wr;
    logic             w_rd;
    logic             w_be_any;
    logic [DW-1:0]    w_rdata;
    logic             w_err;
    logic [CTL_W-1:0] w_ctl_flat;
    logic [W1C_W-1:0] w_w1c_flat;
    logic             w_unused;

    logic [DW-1:0]    r_rdata;
    logic             r_rdack;
    logic             r_wrack;
    logic             r_err;
    logic             r_irq;

    // Upper address bits and byte-offset bits do not take part in decode.
    assign w_idx    = Bus2IP_Addr[ADDR_LSB +: IDX_W];
    assign w_idx_u  = 32'(w_idx);

    // The registered ack doubles as the busy flag, so a held CS can never
    // produce back-to-back acks.
    assign w_busy   = r_rdack | r_wrack;
    assign w_accept = Bus2IP_CS & ~w_busy;
    assign w_wr     = w_accept & ~Bus2IP_RNW;
    assign w_rd     = w_accept &  Bus2IP_RNW;
    assign w_be_any = |Bus2IP_BE;

    assign w_unused = ^{Bus2IP_Addr, ro_regs, w1c_set, w_be_any};

    // ---------------------------------------------------------------- WO / RW
    if (NUM_CTL > 0) begin : g_ctl
        for (genvar k = 0; k < NUM_CTL; k++) begin : g_ctl_reg
            logic [DW-1:0] r_val;
            logic          r_stb;
            logic          w_hit;

            assign w_hit = w_wr & (w_idx_u == 32'(k));

            // Byte-lane merge of write data; strobe when any lane was enabled.
            always_ff @(posedge Bus2IP_Clk) begin
                if (Bus2IP_Reset) begin
                    r_val <= RESET_VALUES[k*DW +: DW];
                    r_stb <= 1'b0;
                end else begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (w_hit && Bus2IP_BE[b]) begin
                            r_val[b*8 +: 8] <= Bus2IP_Data[b*8 +: 8];
                        end
                    end
                    r_stb <= w_hit & w_be_any;
                end
            end

            assign w_ctl_flat[k*DW +: DW] = r_val;
            assign wr_strobe[k]           = r_stb;
        end
    end else begin : g_ctl_none
        assign w_ctl_flat = '0;
        assign wr_strobe  = '0;
    end

    if (NUM_WO_REGS > 0) begin : g_wo_out
        assign wo_regs = w_ctl_flat[0 +: NUM_WO_REGS*DW];
    end else begin : g_wo_none
        assign wo_regs = '0;
    end

    if (NUM_RW_REGS > 0) begin : g_rw_out
        assign rw_regs = w_ctl_flat[NUM_WO_REGS*DW +: NUM_RW_REGS*DW];
    end else begin : g_rw_none
        assign rw_regs = '0;
    end

    // ---------------------------------------------------------------- W1C
    if (NUM_W1C_REGS > 0) begin : g_w1c
        for (genvar k = 0; k < NUM_W1C_REGS; k++) begin : g_w1c_reg
            ipif_w1c_reg #(
                .DATA_WIDTH (DW)
            ) u_w1c (
                .clk     (Bus2IP_Clk),
                .rst     (Bus2IP_Reset),
                .i_wr_en (w_wr & (w_idx_u == 32'(W1C_BASE + k))),
                .i_be    (Bus2IP_BE),
                .i_wdata (Bus2IP_Data),
                .i_set   (w1c_set[k*DW +: DW]),
                .o_q     (w_w1c_flat[k*DW +: DW])
            );
        end
    end else begin : g_w1c_none
        assign w_w1c_flat = '0;
    end

    assign w1c_regs = w_w1c_flat;

    // ---------------------------------------------------------------- RO
    if (NUM_RO_REGS > 0) begin : g_ro
        for (genvar k = 0; k < NUM_RO_REGS; k++) begin : g_ro_stb
            logic r_rd_stb;

            // Read strobe lands with the ack, after the value was captured.
            always_ff @(posedge Bus2IP_Clk) begin
                if (Bus2IP_Reset) begin
                    r_rd_stb <= 1'b0;
                end else begin
                    r_rd_stb <= w_rd & (w_idx_u == 32'(RO_BASE + k));
                end
            end

            assign ro_rd_strobe[k] = r_rd_stb;
        end
    end else begin : g_ro_none
        assign ro_rd_strobe = '0;
    end

    // Read mux and range check; WO reads and out-of-range reads return zero.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_idx_u >= 32'(TOTAL)) begin
            w_err = 1'b1;
        end else begin
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                if (w_idx_u == 32'(RW_BASE + k)) begin
                    w_rdata = w_ctl_flat[(NUM_WO_REGS + k)*DW +: DW];
                end
            end
            for (int k = 0; k < NUM_W1C_REGS; k++) begin
                if (w_idx_u == 32'(W1C_BASE + k)) begin
                    w_rdata = w_w1c_flat[k*DW +: DW];
                end
            end
            for (int k = 0; k < NUM_RO_REGS; k++) begin
                if (w_idx_u == 32'(RO_BASE + k)) begin
                    w_rdata = ro_regs[k*DW +: DW];
                end
            end
        end
    end

    // Bus response: one ack per accepted access, data/error valid with it.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_rdack <= 1'b0;
            r_wrack <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdack <= w_rd;
            r_wrack <= w_wr;
            r_err   <= w_accept & w_err;
            r_rdata <= w_rd ? w_rdata : '0;
        end
    end

    // Interrupt level follows the sticky bits one cycle later.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_w1c_flat;
        end
    end

    assign IP2Bus_Data  = r_rdata;
    assign IP2Bus_RdAck = r_rdack;
    assign IP2Bus_WrAck = r_wrack;
    assign IP2Bus_Error = r_err;
    assign irq          = r_irq;

endmodule : ipif_regs_ext
`default_nettype wire
